retire_trace_tx: RTL and testbench
==================================

// Module: retire_trace_tx
// PURPOSE
//  Retirement trace transmitter and performance counter unit inside pipelined_cpu.
//  Captures retire events: WB-stage register writes and MEM-stage store commits.
//  Queues them in a FIFO and streams each one out as a 3-beat valid/ready packet.
//  Keeps cycle/instret/stall/drop counters so off-chip logic computes CPI without peeking DUT internals.
// PARAMETERS
//  XLEN        64      datapath width of pc/data/counters
//  FIFO_DEPTH  8       event FIFO entries; power of 2, >=2
//  PKT_TAG     8'hA5   header sync byte
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous, active-high reset
//  trace_en       in   1     1 = capture events and count; 0 = freeze counters, no capture
//  wb_reg_write   in   1     WB stage writes register file this cycle
//  wb_rd          in   5     WB destination register
//  wb_write_data  in   XLEN  WB write data
//  wb_pc          in   XLEN  PC of WB instruction
//  mem_store      in   1     store commits to data memory this cycle
//  mem_pc         in   XLEN  PC of committing store
//  mem_store_data in   XLEN  store data
//  hazard_stall   in   1     pipeline stalled this cycle
//  trace_valid    out  1     packet beat valid
//  trace_ready    in   1     sink accepts beat
//  trace_data     out  XLEN  beat payload
//  trace_last     out  1     final beat of packet
//  cycle_count    out  XLEN  cycles while trace_en
//  instret_count  out  XLEN  retired events while trace_en
//  stall_count    out  32    cycles with hazard_stall && trace_en
//  drop_count     out  32    events lost (FIFO full or collision)
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  occupied entries
// BEHAVIOUR
//  Reset (async, immediate):
//   - All outputs 0; FIFO empty; FSM=IDLE; seq=0; trace_valid drops at once, even mid-packet.
//  Events (only when trace_en=1):
//   - REG event: wb_reg_write && wb_rd!=0.
//   - ST event: mem_store; rd field=0, data=mem_store_data, pc=mem_pc.
//  Counting and ordering:
//   - instret_count += number of events this cycle (0, 1 or 2).
//   - seq (32b, wraps) += number of events; dropped events still consume seq, so gaps are visible downstream.
//   - Both events in one cycle: REG is offered for push with seq=old; ST is dropped (drop_count+1, takes seq old+1).
//  FIFO push:
//   - Push needs fifo_level<FIFO_DEPTH sampled at cycle start. A pop in the same cycle does NOT free space.
//   - Push when full -> drop_count+1.
//   - Entry = {is_store, rd, seq, pc, data}.
//  Counters:
//   - cycle_count +1 per cycle while trace_en; stall_count +1 when hazard_stall && trace_en.
//   - XLEN counters wrap; stall_count/drop_count saturate at all-ones.
//  Transmit FSM: IDLE -> HDR -> PC -> DATA -> (HDR if FIFO non-empty after pop, else IDLE)
//   - IDLE: trace_valid=0; go to HDR the cycle after the FIFO becomes non-empty.
//   - HDR beat:  {PKT_TAG[7:0], is_store, rd[4:0], 18'b0, seq[31:0]}
//   - PC beat:   pc
//   - DATA beat: data, trace_last=1
//   - Advance only on trace_valid && trace_ready. trace_data/trace_last stay stable while valid && !ready.
//   - FIFO head pops on DATA beat acceptance; back-to-back packets have no idle cycle.
//  Latency and throughput:
//   - Event at cycle N -> HDR valid at N+2 when FIFO was empty and FSM idle.
//   - Max sustained throughput: 1 event per 3 cycles.
//  trace_en=0 mid-packet: the current packet and queued entries still drain; only capture and counting stop.
// TESTING
//  1 Reset, trace_en=1, one REG event (rd=3, data=5, pc=0x40), ready=1
//    -> beats A5_0C000000_00000000 / 0x40 / 5 (last=1); instret=1.
//  2 Same event, ready low 4 cycles
//    -> HDR held stable for 4 cycles, then PC and DATA beats; no duplicate or lost beat.
//  3 ready=0, 10 consecutive REG events, FIFO_DEPTH=8
//    -> fifo_level=8, drop_count=2, instret=10; drained packet seqs are 0..7.
//  4 REG and ST in the same cycle
//    -> one packet with seq=k; drop_count+1; next event carries seq=k+2.
//  5 Assert rst mid-PC beat
//    -> trace_valid=0 at once; all counters and fifo_level=0; next event gives seq=0.
//  6 hazard_stall high 3 of 5 cycles, then trace_en=0 for 4 cycles
//    -> stall_count=3, cycle_count=5, frozen during disable.

Source files
------------

// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: captures WB register writes and MEM store commits,
// queues them, streams each as a 3-beat packet and keeps CPI counters.
module retire_trace_tx #(
  parameter int         XLEN       = 64,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] PKT_TAG    = 8'hA5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trace_en,
  input  logic                          wb_reg_write,
  input  logic [4:0]                    wb_rd,
  input  logic [XLEN-1:0]               wb_write_data,
  input  logic [XLEN-1:0]               wb_pc,
  input  logic                          mem_store,
  input  logic [XLEN-1:0]               mem_pc,
  input  logic [XLEN-1:0]               mem_store_data,
  input  logic                          hazard_stall,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [XLEN-1:0]               trace_data,
  output logic                          trace_last,
  output logic [XLEN-1:0]               cycle_count,
  output logic [XLEN-1:0]               instret_count,
  output logic [31:0]                   stall_count,
  output logic [31:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PC, S_DATA} state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [1:0] n);
    logic [32:0] s;
    s = {1'b0, a} + {31'b0, n};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  function automatic logic [XLEN-1:0] hdr_beat(input logic is_st, input logic [4:0] rd,
                                               input logic [31:0] seq);
    logic [63:0] h;
    h = {PKT_TAG, is_st, rd, 18'b0, seq};
    return XLEN'(h);
  endfunction

  // Event FIFO storage (data only, never reset)
  logic            fifo_st_q   [FIFO_DEPTH];
  logic [4:0]      fifo_rd_q   [FIFO_DEPTH];
  logic [31:0]     fifo_seq_q  [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];

  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, next_idx;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     seq_q, seq_d;
  logic [XLEN-1:0] cycle_q, cycle_d, instret_q, instret_d;
  logic [31:0]     stall_q, stall_d, drop_q, drop_d;
  state_e          state_q, state_d;
  logic            valid_q, valid_d, last_q, last_d;
  logic [XLEN-1:0] data_q, data_d;

  logic            reg_ev, st_ev, push_req, push, pop, fifo_full, accept;
  logic [1:0]      n_ev, n_drop;
  logic            push_st;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_pc, push_data;

  always_comb begin
    reg_ev    = trace_en && wb_reg_write && (wb_rd != 5'd0);
    st_ev     = trace_en && mem_store;
    n_ev      = {1'b0, reg_ev} + {1'b0, st_ev};
    // Space is judged on the level at cycle start; a same-cycle pop does not help.
    fifo_full = (level_q == LW'(FIFO_DEPTH));
    push_req  = reg_ev || st_ev;
    push      = push_req && !fifo_full;
    push_st   = !reg_ev;
    push_rd   = reg_ev ? wb_rd : 5'd0;
    push_pc   = reg_ev ? wb_pc : mem_pc;
    push_data = reg_ev ? wb_write_data : mem_store_data;
    // A colliding store is always lost; it still consumes seq old+1.
    n_drop    = {1'b0, push_req && fifo_full} + {1'b0, reg_ev && st_ev};

    cycle_d   = trace_en ? cycle_q + XLEN'(1) : cycle_q;
    instret_d = instret_q + XLEN'(n_ev);
    seq_d     = seq_q + 32'(n_ev);
    stall_d   = (trace_en && hazard_stall) ? sat_add32(stall_q, 2'd1) : stall_q;
    drop_d    = sat_add32(drop_q, n_drop);
  end

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    last_d   = last_q;
    pop      = 1'b0;
    accept   = valid_q && trace_ready;
    next_idx = rd_ptr_q + AW'(1);
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          state_d = S_HDR;
          valid_d = 1'b1;
          last_d  = 1'b0;
          data_d  = hdr_beat(fifo_st_q[rd_ptr_q], fifo_rd_q[rd_ptr_q], fifo_seq_q[rd_ptr_q]);
        end
      end
      S_HDR: begin
        if (accept) begin
          state_d = S_PC;
          data_d  = fifo_pc_q[rd_ptr_q];
        end
      end
      S_PC: begin
        if (accept) begin
          state_d = S_DATA;
          data_d  = fifo_data_q[rd_ptr_q];
          last_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (accept) begin
          pop    = 1'b1;
          last_d = 1'b0;
          // Chain straight into the next header; forward a same-cycle push if it is the only one left.
          if (level_q > LW'(1)) begin
            state_d = S_HDR;
            data_d  = hdr_beat(fifo_st_q[next_idx], fifo_rd_q[next_idx], fifo_seq_q[next_idx]);
          end else if (push) begin
            state_d = S_HDR;
            data_d  = hdr_beat(push_st, push_rd, seq_q);
          end else begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            data_d  = '0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
      end
    endcase

    rd_ptr_d = pop  ? next_idx : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= '0;
      seq_q     <= '0;
      cycle_q   <= '0;
      instret_q <= '0;
      stall_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      data_q    <= data_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      seq_q     <= seq_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
      stall_q   <= stall_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_st_q[wr_ptr_q]   <= push_st;
      fifo_rd_q[wr_ptr_q]   <= push_rd;
      fifo_seq_q[wr_ptr_q]  <= seq_q;
      fifo_pc_q[wr_ptr_q]   <= push_pc;
      fifo_data_q[wr_ptr_q] <= push_data;
    end
  end

  assign trace_valid   = valid_q;
  assign trace_data    = data_q;
  assign trace_last    = last_q;
  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
  assign stall_count   = stall_q;
  assign drop_count    = drop_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed bench for retire_trace_tx: packet format, backpressure, overflow,
// collisions, async reset and counter behaviour.
module tb_retire_trace_tx;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst, trace_en, wb_reg_write, mem_store, hazard_stall, trace_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_write_data, wb_pc, mem_pc, mem_store_data;
  logic            trace_valid, trace_last;
  logic [XLEN-1:0] trace_data, cycle_count, instret_count;
  logic [31:0]     stall_count, drop_count;
  logic [3:0]      fifo_level;

  int total = 0;
  int bad   = 0;

  retire_trace_tx #(.XLEN(64), .FIFO_DEPTH(8), .PKT_TAG(8'hA5)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_write_data(wb_write_data), .wb_pc(wb_pc),
    .mem_store(mem_store), .mem_pc(mem_pc), .mem_store_data(mem_store_data),
    .hazard_stall(hazard_stall),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .trace_last(trace_last), .cycle_count(cycle_count), .instret_count(instret_count),
    .stall_count(stall_count), .drop_count(drop_count), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    wb_reg_write = 1'b0; mem_store = 1'b0; hazard_stall = 1'b0;
    wb_rd = 5'd0; wb_pc = '0; wb_write_data = '0; mem_pc = '0; mem_store_data = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; trace_en = 1'b0; trace_ready = 1'b0;
    clear_events();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic reg_event(input logic [4:0] rd, input logic [63:0] pc, input logic [63:0] data);
    wb_reg_write = 1'b1; wb_rd = rd; wb_pc = pc; wb_write_data = data;
  endtask

  task automatic expect_pkt(input string tag, input logic is_st, input logic [4:0] rd,
                            input logic [31:0] seq, input logic [63:0] pc, input logic [63:0] data);
    int n;
    n = 0;
    trace_ready = 1'b1;
    while (!trace_valid && n < 20) begin
      tick();
      n++;
    end
    check_eq({tag, "_valid"}, {63'b0, trace_valid}, 64'd1);
    check_eq({tag, "_hdr"}, trace_data, {8'hA5, is_st, rd, 18'b0, seq});
    check_eq({tag, "_hdr_last"}, {63'b0, trace_last}, 64'd0);
    tick();
    check_eq({tag, "_pc"}, trace_data, pc);
    check_eq({tag, "_pc_last"}, {63'b0, trace_last}, 64'd0);
    tick();
    check_eq({tag, "_data"}, trace_data, data);
    check_eq({tag, "_data_last"}, {63'b0, trace_last}, 64'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_dut();
    check_eq("rst_valid", {63'b0, trace_valid}, 64'd0);
    check_eq("rst_data", trace_data, 64'd0);
    check_eq("rst_instret", instret_count, 64'd0);
    check_eq("rst_cycle", cycle_count, 64'd0);
    check_eq("rst_level", {60'b0, fifo_level}, 64'd0);
    check_eq("rst_drop", {32'b0, drop_count}, 64'd0);

    // Single REG event, exact latency and beat contents
    trace_en = 1'b1; trace_ready = 1'b1;
    reg_event(5'd3, 64'h40, 64'd5);
    tick();
    clear_events();
    check_eq("t1_instret", instret_count, 64'd1);
    check_eq("t1_level", {60'b0, fifo_level}, 64'd1);
    check_eq("t1_valid_early", {63'b0, trace_valid}, 64'd0);
    tick();
    check_eq("t1_hdr_valid", {63'b0, trace_valid}, 64'd1);
    check_eq("t1_hdr", trace_data, 64'hA50C_0000_0000_0000);
    tick();
    check_eq("t1_pc", trace_data, 64'h40);
    check_eq("t1_pc_last", {63'b0, trace_last}, 64'd0);
    tick();
    check_eq("t1_data", trace_data, 64'd5);
    check_eq("t1_data_last", {63'b0, trace_last}, 64'd1);
    tick();
    check_eq("t1_idle", {63'b0, trace_valid}, 64'd0);
    check_eq("t1_level_end", {60'b0, fifo_level}, 64'd0);

    // Backpressure holds the header stable
    trace_ready = 1'b0;
    reg_event(5'd3, 64'h40, 64'd5);
    tick();
    clear_events();
    tick();
    for (int i = 0; i < 4; i++) begin
      check_eq("t2_hold_valid", {63'b0, trace_valid}, 64'd1);
      check_eq("t2_hold_hdr", trace_data, 64'hA50C_0000_0000_0001);
      tick();
    end
    expect_pkt("t2", 1'b0, 5'd3, 32'd1, 64'h40, 64'd5);
    check_eq("t2_idle", {63'b0, trace_valid}, 64'd0);

    // FIFO overflow with the sink stalled
    reset_dut();
    trace_en = 1'b1; trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      reg_event(5'(i + 1), 64'h100 + 64'(4 * i), 64'h1000 + 64'(i));
      tick();
    end
    clear_events();
    check_eq("t3_level", {60'b0, fifo_level}, 64'd8);
    check_eq("t3_drop", {32'b0, drop_count}, 64'd2);
    check_eq("t3_instret", instret_count, 64'd10);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) check_eq("t3_no_gap", {63'b0, trace_valid}, 64'd1);
      expect_pkt("t3", 1'b0, 5'(i + 1), 32'(i), 64'h100 + 64'(4 * i), 64'h1000 + 64'(i));
    end
    check_eq("t3_level_end", {60'b0, fifo_level}, 64'd0);
    check_eq("t3_idle", {63'b0, trace_valid}, 64'd0);

    // REG and ST collide; rd=0 write is not an event; lone store
    reset_dut();
    trace_en = 1'b1; trace_ready = 1'b1;
    reg_event(5'd7, 64'h200, 64'h77);
    mem_store = 1'b1; mem_pc = 64'h204; mem_store_data = 64'h99;
    tick();
    clear_events();
    check_eq("t4_drop", {32'b0, drop_count}, 64'd1);
    check_eq("t4_instret", instret_count, 64'd2);
    check_eq("t4_level", {60'b0, fifo_level}, 64'd1);
    expect_pkt("t4_reg", 1'b0, 5'd7, 32'd0, 64'h200, 64'h77);
    reg_event(5'd0, 64'h208, 64'h1);
    tick();
    clear_events();
    check_eq("t4_rd0_instret", instret_count, 64'd2);
    check_eq("t4_rd0_level", {60'b0, fifo_level}, 64'd0);
    mem_store = 1'b1; mem_pc = 64'h300; mem_store_data = 64'hAB;
    tick();
    clear_events();
    expect_pkt("t4_st", 1'b1, 5'd0, 32'd2, 64'h300, 64'hAB);
    check_eq("t4_instret_end", instret_count, 64'd3);

    // Asynchronous reset in the middle of the PC beat
    reset_dut();
    trace_en = 1'b1; trace_ready = 1'b1;
    reg_event(5'd3, 64'h40, 64'd5);
    tick();
    clear_events();
    tick();
    tick();
    check_eq("t5_pc_before", trace_data, 64'h40);
    #2 rst = 1'b1;
    #1;
    check_eq("t5_valid_async", {63'b0, trace_valid}, 64'd0);
    check_eq("t5_level", {60'b0, fifo_level}, 64'd0);
    check_eq("t5_instret", instret_count, 64'd0);
    check_eq("t5_cycle", cycle_count, 64'd0);
    #2 rst = 1'b0;
    tick();
    reg_event(5'd4, 64'h50, 64'd6);
    tick();
    clear_events();
    expect_pkt("t5_after", 1'b0, 5'd4, 32'd0, 64'h50, 64'd6);

    // Stall and cycle counters, frozen while disabled
    reset_dut();
    trace_en = 1'b1; trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      hazard_stall = (i == 0 || i == 2 || i == 3);
      tick();
    end
    check_eq("t6_stall", {32'b0, stall_count}, 64'd3);
    check_eq("t6_cycle", cycle_count, 64'd5);
    trace_en = 1'b0; hazard_stall = 1'b1;
    reg_event(5'd5, 64'h60, 64'd7);
    mem_store = 1'b1;
    repeat (4) tick();
    clear_events();
    check_eq("t6_stall_frozen", {32'b0, stall_count}, 64'd3);
    check_eq("t6_cycle_frozen", cycle_count, 64'd5);
    check_eq("t6_instret_frozen", instret_count, 64'd0);
    check_eq("t6_level_frozen", {60'b0, fifo_level}, 64'd0);
    check_eq("t6_drop_frozen", {32'b0, drop_count}, 64'd0);
    check_eq("t6_valid", {63'b0, trace_valid}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
